mult16_seq: RTL and testbench

MULT16_SEQ -- requirements
Module: mult16_seq

---
 rtl/hack_pkg.sv | 22 ++
 rtl/And16.sv | 14 +
 rtl/mult16_seq.sv | 143 ++++++++++++++
 tb/tb_mult16_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack-word definitions: word width, counter width and sequencer state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hack_pkg;

   // Hack machine word width.
   localparam int WORD_W = 16;

   // Iteration counter must be able to hold WORD_W itself (16 iterations).
   localparam int CNT_W = $clog2(WORD_W) + 1;

   // Hack data word.
   typedef logic [WORD_W-1:0] word_t;

   // Shift-and-add sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/And16.sv
// 16-bit bitwise AND cell from the Hack gate library.
// Latency: combinational.
// Backpressure: not applicable.
module And16
   import hack_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic [WORD_W-1:0] out
);

   assign out = a & b;

endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 shift-and-add multiplier returning the low 16 bits of a*b.
// Latency: n+1 cycles from acceptance to out_valid (n = 16, or msb(b)+1 with EARLY_EXIT).
// Backpressure: holds product in DONE until out_ready; in_ready is low while busy.
module mult16_seq
   import hack_pkg::*;
#(
   // 1: stop once the remaining multiplier bits are zero; 0: always 16 iterations.
   parameter int EARLY_EXIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] product
);

   state_t           state;
   state_t           state_nxt;
   word_t            mcand;
   word_t            mplier;
   word_t            acc;
   word_t            mask;
   word_t            pp;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             skip_run;
   logic             last_iter;

   // Partial product: multiplicand gated by the current multiplier LSB.
   assign mask = {WORD_W{mplier[0]}};

   And16 u_mask (
      .a   (mcand),
      .b   (mask),
      .out (pp)
   );

   assign accept = in_valid && in_ready;

   // With early exit a zero multiplier needs no iterations at all.
   assign skip_run = (EARLY_EXIT != 0) && (b == '0);

   // The current RUN cycle is the last one when, after this shift, no multiplier
   // bits remain (early exit) or when the 16th iteration is being performed.
   assign last_iter = (EARLY_EXIT != 0) ? (mplier[WORD_W-1:1] == '0)
                                        : (count == CNT_W'(WORD_W - 1));

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = skip_run ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: load operands on acceptance, one shift-and-add step per RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
               end
            end
            RUN: begin
               acc    <= acc + pp;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   // The accumulator is the product; it only carries meaning while out_valid is high.
   assign product = acc;

   // Ready and valid are never high together.
   a_hs_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(in_ready && out_valid));

   // A stalled result keeps its value and its valid.
   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(product)));

   // The iteration counter never exceeds one full word of multiplier bits.
   a_count_range: assert property (@(posedge clk) disable iff (reset)
      (state == RUN) |-> (count < CNT_W'(WORD_W)));

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: two instances (EARLY_EXIT=0 and 1) share stimulus.
// Latency and products are predicted from plain arithmetic on the operands.
// Backpressure, mid-run reset and random operands are exercised in separate tasks.
module tb_mult16_seq;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              out_ready;
   logic [15:0]       a;
   logic [15:0]       b;
   logic              rdy0, rdy1, vld0, vld1;
   logic [15:0]       prod0, prod1;
   logic [1:0]        rdy;
   logic [1:0]        vld;
   logic [1:0][15:0]  prod;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rdy  = {rdy1, rdy0};
   assign vld  = {vld1, vld0};
   assign prod = {prod1, prod0};

   mult16_seq #(.EARLY_EXIT(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy0),
      .a         (a),
      .b         (b),
      .out_valid (vld0),
      .out_ready (out_ready),
      .product   (prod0)
   );

   mult16_seq #(.EARLY_EXIT(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy1),
      .a         (a),
      .b         (b),
      .out_valid (vld1),
      .out_ready (out_ready),
      .product   (prod1)
   );

   // Number of iterations: 16 without early exit, else position of top set bit + 1.
   function automatic int model_n(input int early, input logic [15:0] op_b);
      int n;
      if (early == 0) return 16;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (op_b[i]) n = i + 1;
      end
      return n;
   endfunction

   // Low 16 bits of the full product.
   function automatic logic [15:0] model_p(input logic [15:0] x, input logic [15:0] y);
      int unsigned full;
      full = 32'(x) * 32'(y);
      return full[15:0];
   endfunction

   // Wait (bounded) at negedges until both instances are ready.
   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (rdy !== 2'b11 && k < 60) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (rdy !== 2'b11) begin
         bad++;
         $display("FAIL %s idle_timeout: in_ready=%b want 11", tag, rdy);
      end
   endtask

   // Operands are presented with in_valid=1 at the current negedge; acceptance
   // happens on the next rising edge. Track both instances until each delivers.
   task automatic track_op(input logic [15:0] op_a, input logic [15:0] op_b, input string tag);
      int          lat [2];
      logic [15:0] got [2];
      bit          busy_ok [2];
      logic [15:0] exp_p;
      int          exp_n;
      exp_p = model_p(op_a, op_b);
      for (int i = 0; i < 2; i++) begin
         lat[i]     = -1;
         got[i]     = '0;
         busy_ok[i] = 1'b1;
      end
      for (int k = 1; k <= 40 && (lat[0] < 0 || lat[1] < 0); k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         a = 16'($urandom);
         b = 16'($urandom);
         for (int i = 0; i < 2; i++) begin
            if (lat[i] < 0) begin
               if (rdy[i] !== 1'b0) busy_ok[i] = 1'b0;
               if (vld[i] === 1'b1) begin
                  lat[i] = k;
                  got[i] = prod[i];
               end
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         exp_n = model_n(i, op_b);
         total++;
         if (lat[i] != exp_n + 1) begin
            bad++;
            $display("FAIL %s latency dut%0d: got %0d want %0d (a=%h b=%h)",
                     tag, i, lat[i], exp_n + 1, op_a, op_b);
         end
         total++;
         if (got[i] !== exp_p) begin
            bad++;
            $display("FAIL %s product dut%0d: got %h want %h (a=%h b=%h)",
                     tag, i, got[i], exp_p, op_a, op_b);
         end
         total++;
         if (!busy_ok[i]) begin
            bad++;
            $display("FAIL %s busy_in_ready dut%0d: got 1 want 0 while busy", tag, i);
         end
      end
   endtask

   task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input string tag);
      wait_idle(tag);
      a         = op_a;
      b         = op_b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      track_op(op_a, op_b, tag);
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (rdy[i] !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready dut%0d: got %b want 1", tag, i, rdy[i]);
         end
         total++;
         if (vld[i] !== 1'b0) begin
            bad++;
            $display("FAIL %s out_valid dut%0d: got %b want 0", tag, i, vld[i]);
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset");
      for (int i = 0; i < 2; i++) begin
         total++;
         if (prod[i] !== 16'h0000) begin
            bad++;
            $display("FAIL reset product dut%0d: got %h want 0000", i, prod[i]);
         end
      end
   endtask

   task automatic test_vectors();
      run_op(16'h0003, 16'h0005, "vec_3x5");
      run_op(16'hFFFF, 16'h0002, "vec_ffff_x2");
      run_op(16'h1234, 16'h0000, "vec_b_zero");
      run_op(16'h0100, 16'h0100, "wrap_zero");
      run_op(16'h00FF, 16'h0101, "wrap_ffff");
      run_op(16'hFFFD, 16'h0005, "signed_neg3x5");
      run_op(16'h8000, 16'hFFFF, "signed_min_x_neg1");
      run_op(16'h0001, 16'h8000, "b_msb_only");
   endtask

   task automatic test_random();
      logic [15:0] ra;
      logic [15:0] rb;
      for (int n = 0; n < 25; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rb = rb >> $urandom_range(0, 16);
         run_op(ra, rb, "random");
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_p;
      logic [15:0] na;
      logic [15:0] nb;
      bit          stable_ok [2];
      int          k;
      na = 16'h1357;
      nb = 16'h00A5;
      wait_idle("bp");
      a         = 16'h0ABC;
      b         = 16'h0013;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      exp_p     = model_p(16'h0ABC, 16'h0013);
      k = 0;
      do begin
         @(negedge clk);
         a        = na;
         b        = nb;
         in_valid = 1'b1;
         k++;
      end while (vld !== 2'b11 && k < 40);
      total++;
      if (vld !== 2'b11) begin
         bad++;
         $display("FAIL bp done_timeout: out_valid=%b want 11", vld);
      end
      stable_ok[0] = 1'b1;
      stable_ok[1] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (vld[i] !== 1'b1 || rdy[i] !== 1'b0 || prod[i] !== exp_p) stable_ok[i] = 1'b0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (!stable_ok[i]) begin
            bad++;
            $display("FAIL bp hold dut%0d: out_valid=%b in_ready=%b product=%h want 1/0/%h",
                     i, vld[i], rdy[i], prod[i], exp_p);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_idle("bp_release");
      track_op(na, nb, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      seen = 1'b0;
      wait_idle("rst_mid");
      a         = 16'h7FFF;
      b         = 16'hFFFF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (vld !== 2'b00) seen = 1'b1;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("rst_mid");
      for (int i = 0; i < 2; i++) begin
         total++;
         if (prod[i] !== 16'h0000) begin
            bad++;
            $display("FAIL rst_mid product dut%0d: got %h want 0000", i, prod[i]);
         end
      end
      repeat (20) begin
         @(negedge clk);
         if (vld !== 2'b00) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL rst_mid spurious_out_valid: got 1 want 0");
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      run_op(16'h00C8, 16'h0007, "after_reset");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
